// File: rtl/div_pkg.sv
// Shared types and helpers for the EX-stage integer divider (div_unit).
package div_pkg;

  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    DIV_W  = 2'b00,
    MOD_W  = 2'b01,
    DIV_WU = 2'b10,
    MOD_WU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Signed variants are div.w / mod.w
  function automatic logic is_signed(input div_op_t op);
    return (op == DIV_W) || (op == MOD_W);
  endfunction

  // Remainder-producing variants are mod.w / mod.wu
  function automatic logic is_mod(input div_op_t op);
    return (op == MOD_W) || (op == MOD_WU);
  endfunction

  // Two's-complement magnitude; 0x8000_0000 maps to itself (read as unsigned)
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for div.w/mod.w/div.wu/mod.wu.
// Holds the pipeline via stall_div until the result is ready.
// Optional build macro: DIV_EARLY_OUT_EN (single-cycle trivial cases).
module div_unit
  import div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              stall_dcache,
  input  logic              div_en,
  input  div_op_t           div_op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              stall_div,
  output logic              div_done,
  output logic [DATA_W-1:0] div_result
);

  localparam logic [DATA_W-1:0] ALL0 = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ALL1 = {DATA_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_ITER - 1);

  div_state_t        state_r, state_next;
  div_op_t           op_r;
  logic              neg_q_r, neg_r_r, dz_r;
  logic [DATA_W-1:0] dvs_r, rem_r, quo_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              sgn_s;
  logic [DATA_W-1:0] mag1_s, mag2_s;
  logic [DATA_W:0]   shifted_s;
  logic              no_borrow_s;
  logic [DATA_W-1:0] diff_s, q_fix_s, r_fix_s, result_s;

  // Operand magnitudes and one restoring step on the iteration pair
  always_comb begin
    sgn_s       = is_signed(div_op);
    mag1_s      = sgn_s ? abs32(src1) : src1;
    mag2_s      = sgn_s ? abs32(src2) : src2;
    shifted_s   = {rem_r, quo_r[DATA_W-1]};
    no_borrow_s = (shifted_s >= {1'b0, dvs_r});
    // When no borrow, the true difference is below the divisor and fits DATA_W bits
    diff_s      = shifted_s[DATA_W-1:0] - dvs_r;
    // Divide-by-zero keeps the all-ones quotient unsigned-looking
    q_fix_s     = (neg_q_r && !dz_r) ? (ALL0 - quo_r) : quo_r;
    r_fix_s     = neg_r_r ? (ALL0 - rem_r) : rem_r;
    result_s    = is_mod(op_r) ? r_fix_s : q_fix_s;
  end

`ifdef DIV_EARLY_OUT_EN
  logic              early_s;
  logic [DATA_W-1:0] early_q_s, early_r_s, early_result_s;

  // Trivial cases resolved at accept; signed overflow falls under |src2|==1
  always_comb begin
    early_s = (mag2_s == ALL0) || (mag1_s < mag2_s) ||
              (mag2_s == {{(DATA_W-1){1'b0}}, 1'b1});
    if (mag2_s == ALL0) begin
      early_q_s = ALL1;
      early_r_s = src1;
    end else if (mag1_s < mag2_s) begin
      early_q_s = ALL0;
      early_r_s = src1;
    end else if (sgn_s && (src1[DATA_W-1] ^ src2[DATA_W-1])) begin
      early_q_s = ALL0 - mag1_s;
      early_r_s = ALL0;
    end else begin
      early_q_s = mag1_s;
      early_r_s = ALL0;
    end
    early_result_s = is_mod(div_op) ? early_r_s : early_q_s;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic; flush overrides everything but reset
  always_comb begin
    state_next = state_r;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (div_en) begin
`ifdef DIV_EARLY_OUT_EN
            state_next = early_s ? DONE : BUSY;
`else
            state_next = BUSY;
`endif
          end else begin
            state_next = IDLE;
          end
        end
        BUSY: begin
          if (!div_en) begin
            state_next = IDLE;
          end else if (cnt_r == CNT_LAST) begin
            state_next = FIX;
          end else begin
            state_next = BUSY;
          end
        end
        FIX: begin
          if (!div_en) begin
            state_next = IDLE;
          end else begin
            state_next = DONE;
          end
        end
        DONE: begin
          if (!stall_dcache) begin
            state_next = IDLE;
          end else begin
            state_next = DONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Pipeline freeze request: asserted from the accept cycle until DONE
  always_comb begin
    stall_div = div_en && (state_r != DONE);
  end

  // Operand capture, iteration datapath and registered result
  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_r       <= DIV_W;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      dz_r       <= 1'b0;
      dvs_r      <= ALL0;
      rem_r      <= ALL0;
      quo_r      <= ALL0;
      cnt_r      <= {CNT_W{1'b0}};
      div_result <= ALL0;
      div_done   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (div_en && !flush) begin
            op_r    <= div_op;
            neg_q_r <= sgn_s && (src1[DATA_W-1] ^ src2[DATA_W-1]);
            neg_r_r <= sgn_s && src1[DATA_W-1];
            dz_r    <= (src2 == ALL0);
            dvs_r   <= mag2_s;
            quo_r   <= mag1_s;
            rem_r   <= ALL0;
            cnt_r   <= {CNT_W{1'b0}};
`ifdef DIV_EARLY_OUT_EN
            if (early_s) begin
              div_result <= early_result_s;
            end
`endif
          end
        end
        BUSY: begin
          rem_r <= no_borrow_s ? diff_s : shifted_s[DATA_W-1:0];
          quo_r <= {quo_r[DATA_W-2:0], no_borrow_s};
          cnt_r <= cnt_r + CNT_W'(1);
        end
        FIX: begin
          if (state_next == DONE) begin
            div_result <= result_s;
          end
        end
        DONE: begin
          div_result <= div_result;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
      div_done <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected results and stall
// lengths, a monitor pops and compares on each rising div_done.
module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rstn, flush, stall_dcache, div_en;
  div_op_t     div_op;
  logic [31:0] src1, src2;
  logic        stall_div, div_done;
  logic [31:0] div_result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       name;
  } exp_t;
  exp_t sb[$];

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .stall_dcache(stall_dcache),
    .div_en(div_en), .div_op(div_op), .src1(src1), .src2(src2),
    .stall_div(stall_div), .div_done(div_done), .div_result(div_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input bit early);
`ifdef DIV_EARLY_OUT_EN
    return early ? 1 : 34;
`else
    return 34;
`endif
  endfunction

  // Monitor: count stall cycles, compare on each new result
  initial begin
    int  stall_cnt = 0;
    bit  done_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (div_done && !done_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_res"}, div_result, e.res);
          chk({e.name, "_lat"}, 32'(stall_cnt), 32'(e.lat));
        end
        stall_cnt = 0;
      end else if (stall_div) begin
        stall_cnt++;
      end else begin
        stall_cnt = 0;
      end
      done_prev = div_done;
    end
  end

  // Issue one operation at the next negedge and wait for its DONE cycle
  task automatic run_op(input string name, input div_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit early);
    int n = 0;
    @(negedge clk);
    div_en = 1'b1; div_op = op; src1 = a; src2 = b;
    sb.push_back('{exp, lat_of(early), name});
    while (!div_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!div_done) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    rstn = 1'b0; flush = 1'b0; stall_dcache = 1'b0; div_en = 1'b0;
    div_op = DIV_W; src1 = 32'd0; src2 = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_done", {31'd0, div_done}, 32'd0);
    chk("rst_result", div_result, 32'd0);
    chk("rst_stall_lo", {31'd0, stall_div}, 32'd0);
    div_en = 1'b1;
    #1;
    chk("rst_stall_hi", {31'd0, stall_div}, 32'd1);
    @(negedge clk);
    div_en = 1'b0; rstn = 1'b1;

    // Main function, back-to-back with div_en held
    run_op("div_100_7",   DIV_W,  32'd100,       32'd7,         32'd14,        1'b0);
    run_op("mod_100_7",   MOD_W,  32'd100,       32'd7,         32'd2,         1'b0);
    run_op("mod_m7_2",    MOD_W,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
    run_op("div_m7_2",    DIV_W,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
    run_op("divu_max_2",  DIV_WU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 1'b0);
    run_op("modu_max_2",  MOD_WU, 32'hFFFF_FFFF, 32'd2,         32'd1,         1'b0);
    run_op("div_m100_7",  DIV_W,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0);
    run_op("mod_m100_m7", MOD_W,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
    // Boundary and early-out cases
    run_op("div_5_0",     DIV_W,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1);
    run_op("mod_5_0",     MOD_W,  32'd5,         32'd0,         32'd5,         1'b1);
    run_op("mod_m5_0",    MOD_W,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1);
    run_op("divu_5_0",    DIV_WU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1);
    run_op("div_ovf",     DIV_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("mod_ovf",     MOD_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);
    run_op("divu_3_10",   DIV_WU, 32'd3,         32'd10,        32'd0,         1'b1);
    run_op("mod_m3_10",   MOD_W,  32'hFFFF_FFFD, 32'd10,        32'hFFFF_FFFD, 1'b1);
    run_op("div_7_m1",    DIV_W,  32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    @(negedge clk);
    div_en = 1'b0;

    // Flush in the middle of BUSY
    @(negedge clk);
    div_en = 1'b1; div_op = DIV_W; src1 = 32'd100; src2 = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1; div_en = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_idle", {30'd0, dut.state_r}, {30'd0, IDLE});
    chk("flush_done", {31'd0, div_done}, 32'd0);
    run_op("divu_9_3", DIV_WU, 32'd9, 32'd3, 32'd3, 1'b0);

    // dcache stall across completion, then a back-to-back divide
    @(negedge clk);
    div_en = 1'b1; div_op = DIV_WU; src1 = 32'd1000; src2 = 32'd10;
    sb.push_back('{32'd100, 34, "divu_1000_10"});
    repeat (30) @(negedge clk);
    stall_dcache = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("hold_done", {31'd0, div_done}, 32'd1);
      chk("hold_stall", {31'd0, stall_div}, 32'd0);
      chk("hold_result", div_result, 32'd100);
      @(negedge clk);
    end
    stall_dcache = 1'b0;
    div_op = DIV_W; src1 = 32'd100; src2 = 32'hFFFF_FFF9;
    sb.push_back('{32'hFFFF_FFF2, 34, "div_100_m7"});
    #1;
    chk("hold_last", {31'd0, div_done}, 32'd1);
    @(negedge clk);
    #1;
    chk("release_idle", {30'd0, dut.state_r}, {30'd0, IDLE});
    chk("release_done", {31'd0, div_done}, 32'd0);
    n = 0;
    while (!div_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!div_done) chk("b2b_timeout", 32'd0, 32'd1);
    @(negedge clk);
    div_en = 1'b0;

    // Reset in the middle of an operation
    @(negedge clk);
    div_en = 1'b1; div_op = MOD_W; src1 = 32'd50; src2 = 32'd3;
    repeat (5) @(negedge clk);
    rstn = 1'b0; div_en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("midrst_idle", {30'd0, dut.state_r}, {30'd0, IDLE});
    chk("midrst_result", div_result, 32'd0);
    chk("midrst_done", {31'd0, div_done}, 32'd0);
    run_op("modu_17_5", MOD_WU, 32'd17, 32'd5, 32'd2, 1'b0);
    @(negedge clk);
    div_en = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider in the EX stage, for LoongArch div.w, mod.w, div.wu and mod.wu.
- Drives stall_div into the EX/MEM/WB pipeline register, which freezes all inter-stage registers while the divider is busy.
- Its result is muxed into the EX ALU result path and registered into MEM on the first cycle stall_div is low.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- flush  in  1  pipeline flush (CSR/exception from WB); aborts any operation
- stall_dcache  in  1  dcache stall; pipeline not advancing this cycle
- div_en  in  1  instruction in EX is a divide/mod; level, held by the frozen pipeline
- div_op  in  2  operation select, div_op_t
- src1  in  32  dividend
- src2  in  32  divisor
- stall_div  out  1  combinational: div_en & (state != DONE)
- div_done  out  1  registered; result valid (state == DONE)
- div_result  out  32  registered quotient or remainder

Behaviour:
- Reset (rstn=0 at posedge):
  - state=IDLE, div_done=0, div_result=0, counter=0, internal regs 0.
  - stall_div then follows div_en only.
- States: IDLE, BUSY, FIX, DONE.
- IDLE, div_en=1 and flush=0 at edge t:
  - Latch op, result signs and operand magnitudes (abs for signed ops).
  - Clear partial remainder; counter=0; go to BUSY.
  - stall_div=1 already in cycle t (combinational).
- BUSY: one restoring radix-2 step per cycle.
  - Shift the {remainder, quotient} pair left by 1.
  - Trial-subtract the divisor, 33-bit compare; set the quotient bit on no-borrow.
  - After 32 steps (counter==31), go to FIX.
- FIX:
  - Negate the quotient if the dividend and divisor signs differ (signed ops only).
  - Negate the remainder if the dividend is negative (signed ops only).
  - Select quotient or remainder per op; register div_result; div_done=1; go to DONE.
- Latency: accept at t, DONE at t+34. stall_div high for exactly 34 cycles (t..t+33), low at t+34; the pipeline advances at edge t+34 unless stall_dcache.
- DONE:
  - Hold div_result and div_done.
  - Leave to IDLE at the first edge with stall_dcache=0 (instruction leaves EX); div_done=0 next cycle.
  - stall_dcache=1 keeps DONE indefinitely; stall_div stays 0.
- Operand/op changes after accept are ignored.
- div_en=0 while BUSY/FIX (only legal after a flush): abort to IDLE.
- flush=1 at any edge, any state: go to IDLE, div_done=0. div_result is not cleared. Takes priority over everything except reset.
- Reset mid-operation: same as reset; no residual state.
- Divide by zero, all ops:
  - quotient = 0xFFFF_FFFF; remainder = dividend.
  - This falls out of the restoring algorithm; for signed ops the sign fix is suppressed on the quotient.
- Signed overflow (0x8000_0000 / 0xFFFF_FFFF): quotient = 0x8000_0000, remainder = 0.
- Remainder sign always equals the dividend sign (truncating division).
- After DONE->IDLE with div_en still 1 (the next instruction is also a divide), the new operation is accepted at the following edge.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, when accepting, detect the following cases and go directly to DONE at t+1 with the final result (stall_div high for 1 cycle):
  - divisor zero
  - signed overflow
  - |src1| < |src2| (quotient 0, remainder = src1)
  - |src2| == 1 (quotient = ±|src1|, remainder 0)
- All other cases use the 34-cycle path.
- Undefined: every operation takes 34 cycles; results are identical in both builds.

Decomposition:
- Shared package div_pkg:
  - typedef enum logic[1:0] div_op_t: DIV_W=2'b00, MOD_W=2'b01, DIV_WU=2'b10, MOD_WU=2'b11.
  - typedef enum div_state_t: IDLE, BUSY, FIX, DONE.
  - Constant DIV_ITER=32.
  - Functions: is_signed(op), is_mod(op), abs32.
- No sub-module; the datapath is one iteration register pair plus control in a single module.

Test Plan:
- DIV_W 100/7, div_en held:
  - stall_div high 34 cycles.
  - div_result=14 at t+34.
  - MOD_W same operands -> 2.
- MOD_W 0xFFFF_FFF9 (-7) / 2 -> 0xFFFF_FFFF (-1).
- DIV_W -7/2 -> 0xFFFF_FFFD (-3).
- DIV_WU 0xFFFF_FFFF/2 -> 0x7FFF_FFFF.
- MOD_WU 0xFFFF_FFFF/2 -> 1.
- Special cases (with DIV_EARLY_OUT_EN, stall exactly 1 cycle):
  - DIV_W 5/0 -> 0xFFFF_FFFF.
  - MOD_W 5/0 -> 5.
  - DIV_W 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000.
  - MOD_W on the same operands -> 0.
- flush at BUSY cycle 10:
  - State IDLE next cycle; div_done=0.
  - A new DIV_WU 9/3 issued after is accepted and returns 3 after 34 cycles.
- stall_dcache=1 from t+30 to t+40:
  - DONE held, div_result stable, stall_div=0.
  - Return to IDLE at the edge after stall_dcache drops.
  - A back-to-back second divide restarts correctly.
